// File: rtl/demux8_burst_scheduler_pkg.sv
// demux_sched_pkg: shared types and constants for the 1x8 demux burst scheduler.
//   state_t        - scheduler state encoding (IDLE/XFER/GAP)
//   NUM_CH, SEL_W  - channel count and select width (fixed, not overridable)
//   idx_to_onehot  - 3-bit channel index to 8-bit one-hot grant vector
package demux_sched_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic logic [NUM_CH-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux8_burst_scheduler_if.sv
// demux8_burst_scheduler_if: bundle between the burst scheduler, its serial
// source, the requesters and the 1x8 demux.
//   en, req, din        - requester/source side inputs to the scheduler
//   din_ready           - source handshake: while high, the scheduler consumes
//                         the bit on din in that same cycle; the source must
//                         present the next bit for the following cycle. There
//                         is no source-side valid: the source is assumed always
//                         able to supply a bit when din_ready is high.
//   sel, dout, dout_en  - demux select, data and data-enable
//   gnt, last, busy     - one-hot grant, final-bit strobe, scheduler activity
// Modports: master = requester/source side, slave = scheduler side.
interface demux8_burst_scheduler_if;
    import demux_sched_pkg::*;

    logic              en;
    logic [NUM_CH-1:0] req;
    logic              din;
    logic              din_ready;
    logic [SEL_W-1:0]  sel;
    logic              dout;
    logic              dout_en;
    logic [NUM_CH-1:0] gnt;
    logic              last;
    logic              busy;

    modport master (
        output en, req, din,
        input  din_ready, sel, dout, dout_en, gnt, last, busy
    );

    modport slave (
        input  en, req, din,
        output din_ready, sel, dout, dout_en, gnt, last, busy
    );

endinterface

// File: rtl/demux8_burst_scheduler_rr_pick8.sv
// rr_pick8: combinational round-robin picker.
//   req[7:0] - request vector
//   ptr[2:0] - highest-priority index for this pick
//   found    - any request set
//   idx[2:0] - first set req bit at or after ptr, searching upward with wrap
module rr_pick8
    import demux_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    logic [NUM_CH-1:0] rot;
    logic [SEL_W-1:0]  off;

    always_comb begin
        // Rotate so that rot[0] is req[ptr]; the lowest set bit of rot is then
        // the winner's distance from ptr.
        for (int i = 0; i < NUM_CH; i++) begin
            rot[i] = req[ptr + SEL_W'(i)];
        end
        off = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
        found = |req;
        idx   = ptr + off;
    end

endmodule

// File: rtl/demux8_burst_scheduler.sv
// demux8_burst_scheduler: round-robin burst scheduler in front of a 1x8 demux.
// Grants one requester at a time, streams BURST_LEN serial bits from din to
// the granted output, then idles for GAP_CYCLES guard cycles.
//   clk, rst  - clock, synchronous active-high reset
//   io        - slave side of demux8_burst_scheduler_if
//   dbg_state - current FSM state
//   dbg_ptr   - current round-robin priority pointer
module demux8_burst_scheduler
    import demux_sched_pkg::*;
#(
    parameter int BURST_LEN  = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    demux8_burst_scheduler_if.slave  io,
    output state_t                   dbg_state,
    output logic [SEL_W-1:0]         dbg_ptr
);

    if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_burst_len
        $error("demux8_burst_scheduler: BURST_LEN must be in 1..256");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap_cycles
        $error("demux8_burst_scheduler: GAP_CYCLES must be in 0..15");
    end

    // Wide enough to hold BURST_LEN, since cnt keeps incrementing on the last bit.
    localparam int                CNT_W    = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST_LEN - 1);
    // Unreachable when GAP_CYCLES is 0 because GAP is never entered.
    localparam logic [3:0]        GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         gap_q, gap_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_CH-1:0]  gnt_q, gnt_d;

    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic               in_xfer;
    logic               at_last;

    rr_pick8 u_pick (
        .req   (io.req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (io.en && pick_found) begin
                    sel_d   = pick_idx;
                    gnt_d   = idx_to_onehot(pick_idx);
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Priority moves past the channel just served.
                    ptr_d   = sel_q + SEL_W'(1);
                    gnt_d   = '0;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_xfer = (state_q == XFER);
    assign at_last = in_xfer && (cnt_q == CNT_LAST);

    assign io.dout_en   = in_xfer;
    assign io.din_ready = in_xfer;
    assign io.busy      = (state_q != IDLE);
    assign io.last      = at_last;
    assign io.dout      = io.din & in_xfer;
    assign io.sel       = sel_q;
    assign io.gnt       = gnt_q;

    assign dbg_state = state_q;
    assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_demux8_burst_scheduler.sv
// Bench for demux8_burst_scheduler: two instances (BURST_LEN=4/GAP=1 and
// BURST_LEN=1/GAP=0) share stimulus and are compared every cycle against a
// position-in-period reference model, plus a grant-order scoreboard.
module tb_demux8_burst_scheduler;
    import demux_sched_pkg::*;

    // ---------------- clock / reset / stimulus variables ----------------
    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       din;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    demux8_burst_scheduler_if ifa ();
    demux8_burst_scheduler_if ifb ();

    assign ifa.en  = en;
    assign ifa.req = req;
    assign ifa.din = din;
    assign ifb.en  = en;
    assign ifb.req = req;
    assign ifb.din = din;

    state_t     st_a, st_b;
    logic [2:0] ptr_a, ptr_b;

    demux8_burst_scheduler #(.BURST_LEN(4), .GAP_CYCLES(1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .io        (ifa.slave),
        .dbg_state (st_a),
        .dbg_ptr   (ptr_a)
    );

    demux8_burst_scheduler #(.BURST_LEN(1), .GAP_CYCLES(0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .io        (ifb.slave),
        .dbg_state (st_b),
        .dbg_ptr   (ptr_b)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each DUT is described by whether a grant period is in progress, the
    // cycle position inside it (0..BL-1 burst, BL..BL+GAP-1 guard), the
    // channel being served and the channel that has first priority.
    int bl[2]    = '{4, 1};
    int gp[2]    = '{1, 0};
    bit m_act[2];
    int m_pos[2];
    int m_chan[2];
    int m_ptr[2];

    logic [2:0] exp_qa[$];
    logic [2:0] exp_qb[$];
    bit         prev_en[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_act[d]  = 0;
            m_pos[d]  = 0;
            m_chan[d] = 0;
            m_ptr[d]  = 0;
        end
    endtask

    task automatic model_update();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_act[d]  = 0;
                m_pos[d]  = 0;
                m_chan[d] = 0;
                m_ptr[d]  = 0;
            end else if (m_act[d]) begin
                if (m_pos[d] == bl[d] - 1) m_ptr[d] = (m_chan[d] + 1) % 8;
                m_pos[d]++;
                if (m_pos[d] == bl[d] + gp[d]) m_act[d] = 0;
            end else if (en && req != 8'h00) begin
                for (int k = 7; k >= 0; k--) begin
                    if (req[(m_ptr[d] + k) % 8]) m_chan[d] = (m_ptr[d] + k) % 8;
                end
                m_act[d] = 1;
                m_pos[d] = 0;
            end
        end
    endtask

    task automatic check_dut(input int d, input string nm, input logic din_ready,
                             input logic [2:0] sel, input logic dout, input logic dout_en,
                             input logic [7:0] gnt, input logic last, input logic busy,
                             input state_t st, input logic [2:0] ptr);
        bit     x;
        state_t es;
        x  = m_act[d] && (m_pos[d] < bl[d]);
        es = !m_act[d] ? IDLE : (x ? XFER : GAP);
        check({nm, "_dout_en"},   dout_en,   x);
        check({nm, "_din_ready"}, din_ready, x);
        check({nm, "_busy"},      busy,      m_act[d]);
        check({nm, "_last"},      last,      x && (m_pos[d] == bl[d] - 1));
        check({nm, "_dout"},      dout,      din & x);
        check({nm, "_sel"},       sel,       m_chan[d]);
        check({nm, "_gnt"},       gnt,       x ? (32'd1 << m_chan[d]) : 32'd0);
        check({nm, "_state"},     st,        es);
        check({nm, "_ptr"},       ptr,       m_ptr[d]);
        // Grant-order scoreboard on each new burst start.
        if (dout_en && !prev_en[d]) begin
            if (d == 0 && exp_qa.size() > 0) check("order_a", sel, exp_qa.pop_front());
            if (d == 1 && exp_qb.size() > 0) check("order_b", sel, exp_qb.pop_front());
        end
        prev_en[d] = dout_en;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        check_dut(0, "a", ifa.din_ready, ifa.sel, ifa.dout, ifa.dout_en, ifa.gnt,
                  ifa.last, ifa.busy, st_a, ptr_a);
        check_dut(1, "b", ifb.din_ready, ifb.sel, ifb.dout, ifb.dout_en, ifb.gnt,
                  ifb.last, ifb.busy, st_b, ptr_b);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            din = 1'($urandom_range(0, 1));
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        req = 8'h00;
        din = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic drain_queues(input string nm);
        check({nm, "_qa_drained"}, exp_qa.size(), 0);
        check({nm, "_qb_drained"}, exp_qb.size(), 0);
        exp_qa.delete();
        exp_qb.delete();
    endtask

    // ---------------- main sequence ----------------
    logic [3:0] pat;

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        req = 8'h00;
        din = 1'b0;
        prev_en[0] = 0;
        prev_en[1] = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Single request, directed din pattern 1,0,1,1 across the first burst.
        do_reset();
        en  = 1'b1;
        req = 8'h04;
        din = 1'b0;
        step();
        pat = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            din = pat[i];
            step();
        end
        run(8);

        // Full contention: 16 bursts on the 4/1 instance, 48 on the 1/0 one.
        do_reset();
        for (int i = 0; i < 16; i++) exp_qa.push_back(3'(i % 8));
        for (int i = 0; i < 48; i++) exp_qb.push_back(3'(i % 8));
        en  = 1'b1;
        req = 8'hFF;
        run(97);
        drain_queues("contention");

        // Fairness skip between channels 0 and 7.
        do_reset();
        for (int i = 0; i < 4; i++) exp_qa.push_back((i % 2 == 0) ? 3'd0 : 3'd7);
        for (int i = 0; i < 4; i++) exp_qb.push_back((i % 2 == 0) ? 3'd0 : 3'd7);
        en  = 1'b1;
        req = 8'h81;
        run(25);
        drain_queues("fairness");

        // Drop req and en in the second burst cycle; burst and gap still finish.
        do_reset();
        en  = 1'b1;
        req = 8'h20;
        run(2);
        en  = 1'b0;
        req = 8'h00;
        run(10);
        req = 8'h42;
        run(6);
        en  = 1'b1;
        run(12);

        // Reset in the third XFER cycle, then lowest set bit wins.
        do_reset();
        en  = 1'b1;
        req = 8'h18;
        run(3);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        exp_qa.push_back(3'd3);
        run(3);
        check("rst_mid_qa_drained", exp_qa.size(), 0);
        exp_qa.delete();
        run(8);

        // Corner config alternation 4,5 on the 1/0 instance.
        do_reset();
        for (int i = 0; i < 6; i++) exp_qb.push_back((i % 2 == 0) ? 3'd4 : 3'd5);
        en  = 1'b1;
        req = 8'h30;
        run(13);
        drain_queues("corner");

        // Randomized traffic with occasional en drops and resets.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            if ($urandom_range(0, 2) == 0) req = req & 8'($urandom);
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 99) == 0);
            din = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/demux8_burst_scheduler.md
Name: demux8_burst_scheduler

Overview:
Round-robin scheduler for the 1x8 demultiplexer datapath. It arbitrates among 8 destination requesters and drives the demux select lines and input enable. For each grant it streams a fixed-length serial burst from one source to the winning output. Between bursts it inserts a programmable guard gap. It sits directly in front of the 1x8 demux and owns its select/data-enable inputs.

Parameters:
BURST_LEN, 4, bits per grant; legal range 1..256
GAP_CYCLES, 1, idle guard cycles after each burst; legal range 0..15
NUM_CH, 8, number of demux outputs; fixed at 8, not overridable

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
en  input  1  global enable; gates new grants only
req  input  8  per-channel request, bit i = output i wants data; level-sensitive
din  input  1  serial source data
din_ready  output  1  source must present next bit; a bit is consumed every cycle this is high
sel  output  3  demux select, binary channel index (sel[2] = MSB)
dout  output  1  data to demux input = din & dout_en
dout_en  output  1  burst active
gnt  output  8  one-hot grant, valid only while dout_en=1
last  output  1  high on final bit of a burst
busy  output  1  high in XFER or GAP

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, ptr=0, cnt=0, sel=0, gnt=0, dout_en=0, din_ready=0, last=0, busy=0. Reset overrides everything, including a mid-burst transfer; the burst is abandoned with no completion strobe.
- States: IDLE, XFER, GAP.
- IDLE: if en=1 and req!=0, select the first set req bit at or after ptr, searching upward with wrap from 7 to 0.
  - Register that index into sel and its one-hot into gnt; clear cnt to 0; go to XFER.
  - Otherwise stay in IDLE; sel holds its last value and gnt=0.
- XFER: dout_en=1, din_ready=1, busy=1, dout=din (combinational pass-through).
  - cnt increments each cycle.
  - When cnt==BURST_LEN-1: last=1, and ptr <= sel+1 (mod 8).
  - Next state is GAP if GAP_CYCLES>0, otherwise IDLE.
- GAP: dout_en=0, gnt=0, busy=1. Counts GAP_CYCLES cycles, then goes to IDLE.
- Latency: req sampled high in IDLE at edge N gives gnt/dout_en high from edge N+1. Minimum burst-to-burst period is 1+BURST_LEN+GAP_CYCLES cycles.
- Non-preemptive:
  - A req bit dropping mid-burst does not shorten the burst.
  - en going low mid-burst lets the current burst and its gap complete; no new grant is issued while en=0.
- Simultaneous events: req changes during XFER/GAP are ignored; arbitration samples req only in IDLE.
- Outputs dout_en, din_ready, busy and last are Moore decodes of state/cnt. gnt and sel are registered.
- Width rules: cnt is clog2(BURST_LEN+1) bits wide; the gap counter is 4 bits; ptr and sel are 3 bits and wrap naturally.
- Out-of-range parameters must fail elaboration.

Decomposition:
- Package demux_sched_pkg holds:
  - state encoding IDLE=2'd0, XFER=2'd1, GAP=2'd2
  - NUM_CH=8 and SEL_W=3
  - a function that converts a 3-bit index to an 8-bit one-hot
- Sub-module rr_pick8: purely combinational (req[7:0], ptr[2:0]) -> (found, idx[2:0]), rotate-and-priority-encode.
- The FSM, counters and the registered sel/gnt stay in the top module.

Test Plan:
- Reset then single request (BURST_LEN=4, GAP=1): req=8'h04 held from cycle 1.
  - Cycles 2-5: sel=2, gnt=8'h04, dout_en=1, din_ready=1; last=1 only in cycle 5.
  - Cycle 6: GAP with busy=1 and gnt=0. Next grant issues in cycle 8.
  - din pattern 1,0,1,1 appears on dout in the same cycles.
- Full contention: req=8'hFF continuously; grant order is sel=0,1,2,...,7,0 with 6-cycle spacing. Checked over 16 bursts.
- Fairness skip: req=8'h81 from reset; grants alternate 0,7,0,7. ptr after a channel-7 burst wraps to 0.
- Request drop and en low: drop req and en in the 2nd cycle of a burst. The burst still runs all 4 bits with last asserted, then GAP, then IDLE with no further grants until en=1.
- Reset mid-burst: assert rst in the 3rd XFER cycle. The next cycle shows all outputs 0, last never fired, ptr=0. The following grant goes to the lowest set req bit.
- Corner config (BURST_LEN=1, GAP_CYCLES=0), req=8'h30:
  - grants alternate 4,5 on every other cycle;
  - dout_en and last are both high in each XFER cycle;
  - every XFER is followed by exactly one IDLE cycle.
